sum_ignore_decoder: RTL and testbench
=====================================

# sum_ignore_decoder

Receive end of the pair-sum stream produced by the ignore-filtered summing block. It recovers the original samples from the running sums using d_n = q_n - d_(n-1), checks each recovered value, and buffers it in a small FIFO. It then re-emits the samples as a w-bit stream in which the parameter ign marks idle cycles. The block sits between the sum link and any consumer of the ign-padded sample format.

## Interface
- w, 4, sample width; sums are w+1 bits
- ign, 0, sentinel value driven on d when idle; never emitted as data
- depth, 4, FIFO entries, power of two, at least 2
- clk  in  1  single clock; all state changes on the rising edge
- rst_b  in  1  asynchronous reset, active-low
- s_valid  in  1  s_sum holds a sum
- s_ready  out  1  block can accept a sum this cycle
- s_sum  in  w+1  running pair sum
- resync  in  1  clears the previous-sample register to 0 (mirror of a far-end reset)
- hold  in  1  downstream stall
- d  out  w  recovered sample, or ign when idle
- d_valid  out  1  d carries data
- err  out  1  one-cycle pulse when a sum was rejected
- level  out  log2(depth)+1  FIFO occupancy

## Operation
- **Accept:** a sum is accepted on an edge where s_valid && s_ready.
- **Ready:** s_ready = (level < depth). This is combinational from the count only, so a pop in the same cycle does not raise it.
- **Difference:** diff = s_sum - prev, computed as a (w+2)-bit signed value.
- **Resync:** if resync is high on the accept edge, prev is taken as 0 for this diff.
- **Valid check:** a sum is valid when 0 <= diff <= 2^w-1 and diff != ign.
  - Valid: push diff[w-1:0] into the FIFO and set prev <= diff.
  - Invalid: drop the sum, keep prev unchanged (or 0 if resync), and set err <= 1 for one cycle.
- **Resync without accept:** prev <= 0.
- **Output:**
  - hold=0 and FIFO non-empty: pop the head, d <= head, d_valid <= 1.
  - Otherwise: d <= ign, d_valid <= 0.
- **Same-edge push and pop:** legal when not full; level is unchanged.
- **Ordering:** FIFO order is strict. The pointers are log2(depth) bits and wrap naturally.
- **Reset (rst_b=0, asynchronous):**
  - d=ign, d_valid=0, err=0, prev=0, level=0, FIFO pointers 0, so s_ready=1.
  - Asserting reset mid-operation discards all queued samples.
- **No FSM beyond the FIFO control.** The occupancy count is the state: EMPTY (level=0), PARTIAL, FULL (level=depth).

## Timing
- Sum accepted at edge N with an empty FIFO and hold=0: the sample is on d/d_valid after edge N+1, a 2-edge latency from presentation.
- A sum arriving into an empty FIFO is never bypassed; it always passes through the FIFO.
- err rises after the accept edge and falls after the next edge unless another rejection follows.
- With hold=0 the throughput is one sample per cycle, sustained.
- The FIFO fills only under hold.
- rst_b deassertion takes effect at the next rising edge; there are no glitches on d during reset.

## Structure
- **Shared package sum_ignore_pkg:**
  - default W=4 and IGN=0, shared with the summing block
  - a function computing the sum width (w+1)
  - the diff-range check as a function, reusable by verification
- **Sub-module sum_fifo:** parameters width and depth; push/pop/full/empty/level; synchronous write, registered head.
- **Top level:** the subtract/check stage, the prev register, and the output register.

## Test plan
Defaults (w=4, ign=0, depth=4) unless a scenario says otherwise.
- **Basic recovery:** reset, then sums 7, 10, 5, 11 on consecutive cycles. Required: d=7, 3, 2, 9 with d_valid=1, each one edge after its accept. Idle cycles show d=0, d_valid=0.
- **Sentinel rejection:** after sum 7, sum 7 (diff 0 = ign). Required: err pulse, nothing pushed, prev stays 7. The next sum 10 yields d=3.
- **Range errors:** with prev=15:
  - sum 5 (diff -10): err.
  - sum 31 (diff 16): err.
  - sum 30: d=15, no err.
- **Backpressure:** hold=1 for 6 cycles with s_valid=1 every cycle (sums 1, 3, 5, 7, 9, 11). Required: 4 accepts, then s_ready=0 with level=4. After releasing hold, d=1, 2, 3, 4 on consecutive cycles.
- **Reset mid-drain:** rst_b low with 3 samples queued. Required: d=0 and d_valid=0 immediately, level=0. After release, sum 9 yields d=9.
- **Changed parameters (ign=14, w=8):**
  - ign=14: diff 14 gives err.
  - resync together with sum 200: d=200, and sum 255 then yields d=55.
  - w=8: sum 510 after prev 255 yields d=255.

Source files
------------

// File: rtl/sum_ignore_pkg.sv
// Shared definitions for the ignore-filtered pair-sum link.
// Holds the default sample width and idle sentinel, the sum-width helper
// and the recovered-difference acceptance rule used by the decoder.
package sum_ignore_pkg;

  localparam int unsigned W   = 4;
  localparam int unsigned IGN = 0;

  // Running pair sums carry one extra bit over the samples.
  function automatic int unsigned sum_width(input int unsigned w);
    return w + 1;
  endfunction

  // A recovered difference is usable when it is a representable sample
  // and does not collide with the idle sentinel.
  function automatic logic diff_ok(input int diff, input int unsigned w,
                                   input int unsigned ign);
    return (diff >= 0) && (diff <= int'((1 << w) - 1)) && (diff != int'(ign));
  endfunction

endpackage

// File: rtl/sum_fifo.sv
// Small synchronous FIFO for recovered samples.
// Ports: clk, rst_b (async, active-low); push/wdata write on the rising edge,
// pop advances the head; head is read from flop storage; full/empty/level
// reflect the registered occupancy count.
module sum_fifo #(
  parameter int unsigned width = 4,
  parameter int unsigned depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     push,
  input  logic [width-1:0]         wdata,
  input  logic                     pop,
  output logic [width-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   level
);

  localparam int unsigned AW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  // Guard against overflow/underflow so the count can never drift.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(depth));
  assign empty = (count == '0);
  assign level = count;

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers are power-of-two sized and wrap naturally.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sum_ignore_decoder.sv
// Receive end of the pair-sum link: recovers samples as d_n = q_n - d_(n-1),
// rejects out-of-range or sentinel-valued differences, buffers good samples
// in a FIFO and re-emits them with ign marking idle cycles.
// Ports: clk, rst_b (async, active-low); s_valid/s_ready/s_sum sum input;
// resync clears the previous-sample register; hold stalls the output;
// d/d_valid registered sample output; err one-cycle reject pulse;
// level FIFO occupancy.
module sum_ignore_decoder
  import sum_ignore_pkg::*;
#(
  parameter int unsigned w     = W,
  parameter int unsigned ign   = IGN,
  parameter int unsigned depth = 4
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [sum_width(w)-1:0]   s_sum,
  input  logic                      resync,
  input  logic                      hold,
  output logic [w-1:0]              d,
  output logic                      d_valid,
  output logic                      err,
  output logic [$clog2(depth):0]    level
);

  localparam int unsigned SW = sum_width(w);
  localparam int unsigned DW = SW + 1;

  logic [w-1:0]          prev_q;
  logic [w-1:0]          prev_eff_c;
  logic signed [DW-1:0]  diff_c;
  logic                  accept_c;
  logic                  ok_c;
  logic                  push_c;
  logic                  pop_c;
  logic                  full_c;
  logic                  empty_c;
  logic [w-1:0]          head_c;

  // Ready depends on the registered count only; a same-cycle pop does not help.
  assign s_ready  = !full_c;
  assign accept_c = s_valid && s_ready;

  // Resync on the accept edge makes this diff relative to zero.
  assign prev_eff_c = resync ? '0 : prev_q;
  assign diff_c     = $signed({1'b0, s_sum}) - $signed({2'b00, prev_eff_c});
  assign ok_c       = diff_ok(int'(diff_c), w, ign);

  assign push_c = accept_c && ok_c;
  assign pop_c  = !hold && !empty_c;

  sum_fifo #(
    .width (w),
    .depth (depth)
  ) u_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (push_c),
    .wdata (diff_c[w-1:0]),
    .pop   (pop_c),
    .head  (head_c),
    .full  (full_c),
    .empty (empty_c),
    .level (level)
  );

  // Previous recovered sample; a rejected sum leaves it alone unless resync.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      prev_q <= '0;
    end else if (push_c) begin
      prev_q <= diff_c[w-1:0];
    end else if (resync) begin
      prev_q <= '0;
    end
  end

  // Reject pulse lasts exactly one cycle per rejected sum.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      err <= 1'b0;
    end else begin
      err <= accept_c && !ok_c;
    end
  end

  // Output register: idle cycles carry the sentinel.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      d       <= w'(ign);
      d_valid <= 1'b0;
    end else if (pop_c) begin
      d       <= head_c;
      d_valid <= 1'b1;
    end else begin
      d       <= w'(ign);
      d_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sum_ignore_decoder.sv
module tb_sum_ignore_decoder;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  // Default instance: w=4, ign=0, depth=4
  logic       s_valid0, s_ready0, resync0, hold0, d_valid0, err0;
  logic [4:0] s_sum0;
  logic [3:0] d0;
  logic [2:0] level0;

  // Changed-parameter instance: w=8, ign=14, depth=4
  logic       s_valid1, s_ready1, resync1, hold1, d_valid1, err1;
  logic [8:0] s_sum1;
  logic [7:0] d1;
  logic [2:0] level1;

  sum_ignore_decoder #(.w(4), .ign(0), .depth(4)) dut0 (
    .clk(clk), .rst_b(rst_b), .s_valid(s_valid0), .s_ready(s_ready0),
    .s_sum(s_sum0), .resync(resync0), .hold(hold0), .d(d0),
    .d_valid(d_valid0), .err(err0), .level(level0)
  );

  sum_ignore_decoder #(.w(8), .ign(14), .depth(4)) dut1 (
    .clk(clk), .rst_b(rst_b), .s_valid(s_valid1), .s_ready(s_ready1),
    .s_sum(s_sum1), .resync(resync1), .hold(hold1), .d(d1),
    .d_valid(d_valid1), .err(err1), .level(level1)
  );

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  // Reference model state: last recovered sample, FIFO occupancy,
  // expected err after the coming edge, and expected output order.
  int mprev[2];
  int mcnt[2];
  bit errx[2];
  int exp0[$];
  int exp1[$];

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic bit ref_ok(input int diff, input int wv, input int ignv);
    return (diff >= 0) && (diff < (1 << wv)) && (diff != ignv);
  endfunction

  // Predict one edge for instance k from its current inputs.
  task automatic step(input int k, input bit v, input int sum, input bit rs, input bit hd);
    int wv, ignv, base, diff;
    bit acc, pop;
    wv   = (k == 0) ? 4 : 8;
    ignv = (k == 0) ? 0 : 14;
    if (k == 0) begin
      chk("ready0", int'(s_ready0), int'(mcnt[0] < 4));
      chk("level0", int'(level0), mcnt[0]);
    end else begin
      chk("ready1", int'(s_ready1), int'(mcnt[1] < 4));
      chk("level1", int'(level1), mcnt[1]);
    end
    acc = v && (mcnt[k] < 4);
    pop = !hd && (mcnt[k] > 0);
    base = rs ? 0 : mprev[k];
    if (rs) mprev[k] = 0;
    errx[k] = 1'b0;
    if (acc) begin
      diff = sum - base;
      if (ref_ok(diff, wv, ignv)) begin
        if (k == 0) exp0.push_back(diff);
        else        exp1.push_back(diff);
        mprev[k] = diff;
        mcnt[k]++;
      end else begin
        errx[k] = 1'b1;
      end
    end
    if (pop) mcnt[k]--;
  endtask

  // Drive instance k for one cycle; the other instance idles.
  task automatic cyc(input int k, input bit v, input int sum, input bit rs, input bit hd);
    if (k == 0) begin
      s_valid0 = v; s_sum0 = 5'(sum); resync0 = rs; hold0 = hd;
      s_valid1 = 1'b0; s_sum1 = '0; resync1 = 1'b0; hold1 = 1'b0;
      step(0, v, sum, rs, hd);
      step(1, 1'b0, 0, 1'b0, 1'b0);
    end else begin
      s_valid1 = v; s_sum1 = 9'(sum); resync1 = rs; hold1 = hd;
      s_valid0 = 1'b0; s_sum0 = '0; resync0 = 1'b0; hold0 = 1'b0;
      step(1, v, sum, rs, hd);
      step(0, 1'b0, 0, 1'b0, 1'b0);
    end
    @(posedge clk);
    #1;
    chk("err0", int'(err0), int'(errx[0]));
    chk("err1", int'(err1), int'(errx[1]));
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) cyc(k, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic rand_run(input int k, input int n);
    int wv, sum;
    for (int i = 0; i < n; i++) begin
      wv = (k == 0) ? 4 : 8;
      if ($urandom % 3 == 0) sum = int'($urandom % (2 << wv));
      else sum = mprev[k] + int'($urandom % (1 << wv));
      cyc(k, ($urandom % 4) != 0, sum, ($urandom % 16) == 0, ($urandom % 4) == 0);
    end
  endtask

  // Monitor: every output cycle is checked against the scoreboard.
  always @(negedge clk) begin
    int x;
    if (mon_en) begin
      if (d_valid0) begin
        if (exp0.size() == 0) chk("d0_extra", 1, 0);
        else begin x = exp0.pop_front(); chk("d0", int'(d0), x); end
      end else chk("d0_idle", int'(d0), 0);
      if (d_valid1) begin
        if (exp1.size() == 0) chk("d1_extra", 1, 0);
        else begin x = exp1.pop_front(); chk("d1", int'(d1), x); end
      end else chk("d1_idle", int'(d1), 14);
    end
  end

  initial begin
    s_valid0 = 0; s_sum0 = '0; resync0 = 0; hold0 = 0;
    s_valid1 = 0; s_sum1 = '0; resync1 = 0; hold1 = 0;
    #2 rst_b = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_d0", int'(d0), 0);
    chk("rst_dvalid0", int'(d_valid0), 0);
    chk("rst_err0", int'(err0), 0);
    chk("rst_level0", int'(level0), 0);
    chk("rst_ready0", int'(s_ready0), 1);
    chk("rst_d1", int'(d1), 14);
    rst_b = 1'b1;

    // Basic recovery: 7,10,5,11 -> 7,3,2,9
    cyc(0, 1, 7, 0, 0); cyc(0, 1, 10, 0, 0); cyc(0, 1, 5, 0, 0); cyc(0, 1, 11, 0, 0);
    idle(0, 3);

    // Sentinel rejection: diff 0 after prev 7, then 10 -> 3
    cyc(0, 1, 7, 1, 0); cyc(0, 1, 7, 0, 0); cyc(0, 1, 10, 0, 0);
    idle(0, 2);

    // Range errors with prev 15
    cyc(0, 1, 15, 1, 0); cyc(0, 1, 5, 0, 0); cyc(0, 1, 31, 0, 0); cyc(0, 1, 30, 0, 0);
    idle(0, 2);

    // Backpressure: six offers under hold, only four fit
    cyc(0, 1, 1, 1, 1);
    cyc(0, 1, 3, 0, 1); cyc(0, 1, 5, 0, 1); cyc(0, 1, 7, 0, 1);
    cyc(0, 1, 9, 0, 1); cyc(0, 1, 11, 0, 1);
    chk("bp_level", int'(level0), 4);
    chk("bp_ready", int'(s_ready0), 0);
    idle(0, 6);

    // Reset mid-drain: fill, emit one, then reset with three queued
    cyc(0, 1, 2, 1, 1); cyc(0, 1, 5, 0, 1); cyc(0, 1, 7, 0, 1); cyc(0, 1, 9, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("pre_rst_dvalid", int'(d_valid0), 1);
    chk("pre_rst_level", int'(level0), 3);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_d0", int'(d0), 0);
    chk("mid_rst_dvalid0", int'(d_valid0), 0);
    chk("mid_rst_level0", int'(level0), 0);
    chk("mid_rst_ready0", int'(s_ready0), 1);
    exp0.delete(); exp1.delete();
    for (int k = 0; k < 2; k++) begin mprev[k] = 0; mcnt[k] = 0; errx[k] = 0; end
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    cyc(0, 1, 9, 0, 0);
    idle(0, 2);

    rand_run(0, 300);
    idle(0, 8);
    chk("drain0", exp0.size(), 0);

    // Changed parameters: w=8, ign=14
    cyc(1, 1, 200, 1, 0); cyc(1, 1, 255, 0, 0); cyc(1, 1, 69, 0, 0);
    cyc(1, 1, 255, 1, 0); cyc(1, 1, 510, 0, 0);
    idle(1, 3);

    rand_run(1, 200);
    idle(1, 8);
    chk("drain1", exp1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
